path_delay_meter: RTL and testbench
===================================

# path_delay_meter

Launch-and-capture measurement stage that drives the input of a delay-chain path under test and times the returning transition in clock cycles. Sits directly upstream/downstream of the chained path: its `path_in` output feeds the path input, and the path result returns on `path_out`. Produces one delay figure per `start` request, optionally averaged over several launches, for comparison against a golden (trojan-free) baseline.

## Interface
Parameters:
- `CNT_W`, 16: width of the cycle counter and `delay_cycles`.
- `SYNC_STAGES`, 2: flip-flop synchronizer depth on `path_out` (minimum 2).
- `SETTLE_CYC`, 8: cycles `path_in` is held low, after `path_out` reads low, before launch.
- `TIMEOUT`, 4095: maximum cycles counted per launch; must be < 2^CNT_W.
- `LOG2_RUNS`, 3: log2 of launches averaged (only with `PATH_DELAY_AVG_EN`).

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  measurement request; sampled only in IDLE.
- `path_out`  in  1  asynchronous result from the path under test.
- `path_in`  out  1  launch drive to the path under test.
- `busy`  out  1  high from the cycle after accepted `start` until `done`.
- `done`  out  1  one-cycle pulse; `delay_cycles`/`timeout` valid from this cycle.
- `delay_cycles`  out  CNT_W  measured (or averaged) delay in cycles.
- `timeout`  out  1  set if any launch in the measurement reached `TIMEOUT`.

## Operation
- States: IDLE, SETTLE, LAUNCH, MEASURE, ACCUM, DONE.
- IDLE: `path_in`=0, `busy`=0. `start`=1 → SETTLE; clears accumulator, run counter and `timeout`.
- SETTLE: `path_in`=0; settle counter counts only while synchronized `path_out` is 0 and restarts when it reads 1; after `SETTLE_CYC` consecutive low cycles → LAUNCH. Stuck-high `path_out` keeps the block in SETTLE until `rst`.
- LAUNCH: one cycle; `path_in` registered to 1; cycle counter cleared to 0 → MEASURE.
- MEASURE: counter increments each cycle; the first cycle synchronized `path_out`=1 → ACCUM with count = cycles elapsed since `path_in` rose, including `SYNC_STAGES` synchronizer latency (no compensation). If count reaches `TIMEOUT` first, sample = `TIMEOUT`, `timeout` set, → ACCUM.
- ACCUM: adds sample to an accumulator of width CNT_W+LOG2_RUNS (no overflow possible); `path_in` returns to 0. More runs pending → SETTLE; else → DONE.
- DONE: `done`=1 one cycle, `delay_cycles` updated, → IDLE. `start` high during DONE is ignored; a new `start` is accepted from IDLE on the next cycle.
- `delay_cycles` and `timeout` hold their value until the next DONE.
- `start` while `busy` is ignored (no queuing).

## Timing
- Reset values: `path_in`=0, `busy`=0, `done`=0, `delay_cycles`=0, `timeout`=0, state IDLE, synchronizer flops 0.
- `rst` mid-measurement aborts immediately; outputs return to reset values asynchronously; no `done` issued.
- Single-run latency, `start` to `done`: 1 + SETTLE_CYC + 1 + sample + 1 + 1 cycles (path low from the start).
- Sample for a path of D cycles of real delay (D≥0): D + SYNC_STAGES, ±1 for metastability resolution.
- Averaged result: accumulator >> LOG2_RUNS (truncating).

## Configuration
- `PATH_DELAY_AVG_EN` defined: 2^LOG2_RUNS launches per `start`, `delay_cycles` = truncated mean, `timeout` is the OR over all runs.
- Not defined: exactly one launch; `delay_cycles` = that sample; `LOG2_RUNS` unused; accumulator width = CNT_W.

## Test plan
- Reset: assert `rst` asynchronously mid-MEASURE → `path_in`=0, `busy`=0, `delay_cycles`=0 before the next edge; no `done`.
- Behavioural path delay of 5 cycles, SYNC_STAGES=2, macro off: `start` → `done` once, `delay_cycles`=7, `timeout`=0, `busy` high throughout.
- Path never rises, TIMEOUT=100: `delay_cycles`=100, `timeout`=1, `done` after 1+8+1+100+2 cycles.
- Macro on, LOG2_RUNS=2, per-launch delays 5,6,5,6 (SYNC 2): accumulator 30 → `delay_cycles`=7, exactly 4 rising edges on `path_in`.
- `path_out` held high for 20 cycles after `start`: no launch until 8 consecutive low cycles; `start` pulses during `busy` and during DONE ignored.
- Back-to-back: `start` held high continuously → new measurement accepted in IDLE one cycle after each `done`.

Source files
------------

// File: rtl/path_delay_meter.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : path_delay_meter
// Description : Launches a rising edge into a path under test and counts the
//               cycles until the synchronized return; optional averaging via
//               PATH_DELAY_AVG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module path_delay_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE_CYC  = 8,
  parameter int TIMEOUT     = 4095,
  parameter int LOG2_RUNS   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             path_out,
  output logic             path_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] delay_cycles,
  output logic             timeout
);

`ifdef PATH_DELAY_AVG_EN
  localparam int RUNS_LOG2 = LOG2_RUNS;
`else
  // Single launch per request: the run count collapses to one.
  localparam int RUNS_LOG2 = 0 * LOG2_RUNS;
`endif

  localparam int ACC_W = CNT_W + RUNS_LOG2;
  localparam int RUN_W = (RUNS_LOG2 > 0) ? RUNS_LOG2 : 1;
  localparam int SET_W = $clog2(SETTLE_CYC + 1);

  localparam logic [RUN_W-1:0] RUN_LAST    = RUN_W'((1 << RUNS_LOG2) - 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(TIMEOUT);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETTLE  = 3'd1;
  localparam logic [2:0] S_LAUNCH  = 3'd2;
  localparam logic [2:0] S_MEASURE = 3'd3;
  localparam logic [2:0] S_ACCUM   = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]             state;
  logic [2:0]             state_nxt;
  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   path_sync;
  logic [SET_W-1:0]       settle_cnt;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       sample;
  logic [ACC_W-1:0]       acc;
  logic [ACC_W-1:0]       acc_sum;
  logic [RUN_W-1:0]       run_cnt;
  logic                   last_run;
  logic                   to_flag;
  logic                   path_in_r;
  logic [CNT_W-1:0]       delay_r;
  logic                   timeout_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], path_out};
    end
  end

  assign path_sync = sync_ff[SYNC_STAGES-1];
  assign last_run  = (run_cnt == RUN_LAST);
  assign acc_sum   = acc + ACC_W'(sample);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (start) state_nxt = S_SETTLE;
      S_SETTLE:  if (!path_sync && settle_cnt == SETTLE_LAST) state_nxt = S_LAUNCH;
      S_LAUNCH:  state_nxt = S_MEASURE;
      S_MEASURE: if (path_sync || cnt == CNT_MAX) state_nxt = S_ACCUM;
      S_ACCUM:   state_nxt = last_run ? S_DONE : S_SETTLE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      path_in_r  <= 1'b0;
      settle_cnt <= '0;
      cnt        <= '0;
      sample     <= '0;
      acc        <= '0;
      run_cnt    <= '0;
      to_flag    <= 1'b0;
      delay_r    <= '0;
      timeout_r  <= 1'b0;
    end else begin
      // The drive is high exactly while a measurement window is open.
      path_in_r <= (state_nxt == S_MEASURE);
      unique case (state)
        S_IDLE: begin
          if (start) begin
            acc        <= '0;
            run_cnt    <= '0;
            to_flag    <= 1'b0;
            settle_cnt <= '0;
          end
        end
        S_SETTLE: begin
          if (path_sync) settle_cnt <= '0;
          else           settle_cnt <= settle_cnt + 1'b1;
        end
        S_LAUNCH: begin
          cnt        <= '0;
          settle_cnt <= '0;
        end
        S_MEASURE: begin
          if (path_sync) begin
            sample <= cnt;
          end else if (cnt == CNT_MAX) begin
            sample  <= CNT_MAX;
            to_flag <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_ACCUM: begin
          acc <= acc_sum;
          if (last_run) begin
            delay_r   <= CNT_W'(acc_sum >> RUNS_LOG2);
            timeout_r <= to_flag;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign path_in      = path_in_r;
  assign delay_cycles = delay_r;
  assign timeout      = timeout_r;

endmodule
`default_nettype wire

// File: tb/tb_path_delay_meter.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : tb_path_delay_meter
// Description : Scoreboard bench for path_delay_meter with a behavioural path.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_path_delay_meter;

  localparam int CNT_W = 16;

`ifdef PATH_DELAY_AVG_EN
  localparam int RUNS = 4, LAT_D5 = 76, LAT_TMO = 445, LAT_D0 = 56;
  localparam int LAT_STUCK = 97, LAT_D3 = 68, LAT_MIX = 78;
`else
  localparam int RUNS = 1, LAT_D5 = 19, LAT_TMO = 112, LAT_D0 = 14;
  localparam int LAT_STUCK = 40, LAT_D3 = 17, LAT_MIX = 19;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             path_out;
  logic             path_in;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] delay_cycles;
  logic             timeout;

  always #5 clk = ~clk;

  path_delay_meter #(
    .CNT_W(CNT_W), .SYNC_STAGES(2), .SETTLE_CYC(8), .TIMEOUT(100), .LOG2_RUNS(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .path_out(path_out),
    .path_in(path_in), .busy(busy), .done(done),
    .delay_cycles(delay_cycles), .timeout(timeout)
  );

  // Behavioural path: output follows path_in after cur_d cycles of high drive.
  longint cyc = 0;
  int     hi_cnt = 0;
  int     rises = 0;
  int     falls = 0;
  int     fall_base = 0;
  logic   pin_q = 1'b0;
  logic   force_high = 1'b0;
  int     dly_tab [4];

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    pin_q  <= path_in;
    hi_cnt <= path_in ? hi_cnt + 1 : 0;
    if (path_in && !pin_q) rises <= rises + 1;
    if (!path_in && pin_q) falls <= falls + 1;
  end

  always_comb path_out = force_high | (path_in && hi_cnt >= dly_tab[(falls - fall_base) & 3]);

  typedef struct {
    int     delay;
    bit     tmo;
    longint start_cyc;
    longint done_cyc;
    int     rises;
    int     rise_base;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  bit   gap = 1'b0;

  task automatic check(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!busy && sb.size() > 0 && cyc > sb[0].start_cyc) gap = 1'b1;
      if (done) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done=1, expected 0");
        end else begin
          e = sb.pop_front();
          check("delay_cycles", delay_cycles, e.delay);
          check("timeout", timeout, e.tmo);
          check("done_cycle", cyc, e.done_cyc);
          check("busy_gap", gap, 0);
          check("launches", rises - e.rise_base, e.rises);
          gap = 1'b0;
        end
      end
    end
  endtask

  task automatic set_delay(input int d0, input int d1, input int d2, input int d3);
    dly_tab[0] = d0; dly_tab[1] = d1; dly_tab[2] = d2; dly_tab[3] = d3;
    fall_base = falls;
  endtask

  task automatic wait_until(input longint target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  // Single request: pulse start for one cycle and queue the expected result.
  task automatic issue(input int delay, input bit tmo, input int lat, input int nr);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    e.delay = delay; e.tmo = tmo; e.start_cyc = cyc; e.done_cyc = cyc + lat;
    e.rises = nr; e.rise_base = rises;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    drain();
  endtask

  initial begin
    exp_t   e;
    longint n;
    set_delay(5, 5, 5, 5);
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_path_in", path_in, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_delay", delay_cycles, 0);
    check("rst_timeout", timeout, 0);

    // Path delay 5: sample 7.
    set_delay(5, 5, 5, 5);
    issue(7, 1'b0, LAT_D5, RUNS);

    // Asynchronous reset in the middle of MEASURE.
    @(negedge clk);
    start = 1'b1;
    n = cyc;
    @(negedge clk);
    start = 1'b0;
    wait_until(n + 15);
    check("launch_before_rst", path_in, 1);
    #1 rst = 1'b1;
    #1;
    check("abort_path_in", path_in, 0);
    check("abort_busy", busy, 0);
    check("abort_delay", delay_cycles, 0);
    check("abort_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);

    // Path never rises: saturate at TIMEOUT.
    set_delay(1000, 1000, 1000, 1000);
    issue(100, 1'b1, LAT_TMO, RUNS);

    // Zero real delay: only the synchronizer latency remains; timeout clears.
    set_delay(0, 0, 0, 0);
    issue(2, 1'b0, LAT_D0, RUNS);

    // path_out held high for 20 cycles; start pulses while busy and in DONE.
    set_delay(5, 5, 5, 5);
    force_high = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b1;
    n = cyc;
    e.delay = 7; e.tmo = 1'b0; e.start_cyc = n; e.done_cyc = n + LAT_STUCK;
    e.rises = RUNS; e.rise_base = rises;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    wait_until(n + 5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(n + 20);
    force_high = 1'b0;
    wait_until(n + LAT_STUCK);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    check("idle_after_done_start", busy, 0);

    // Back-to-back with start held high: two measurements, one idle cycle apart.
    set_delay(3, 3, 3, 3);
    @(negedge clk);
    start = 1'b1;
    n = cyc;
    e.delay = 5; e.tmo = 1'b0; e.start_cyc = n; e.done_cyc = n + LAT_D3;
    e.rises = RUNS; e.rise_base = rises;
    sb.push_back(e);
    e.start_cyc = n + LAT_D3 + 1; e.done_cyc = n + 2 * LAT_D3 + 1;
    e.rise_base = rises + RUNS;
    sb.push_back(e);
    wait_until(n + LAT_D3 + 2);
    start = 1'b0;
    drain();

    // Per-launch delays 5,6,5,6: averaged (30 >> 2 = 7) or first launch only.
    set_delay(5, 6, 5, 6);
    issue(7, 1'b0, LAT_MIX, RUNS);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
